// File: rtl/negate_arbiter.sv
// Round-robin arbiter sharing one two's-complement negate unit between two requesters.
// Optional overflow flag output OVF is built when NEG_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for REQ0/REQ1, arbitration happens here
// CAPT  | operand latched, grant pulse out, result computed at next edge
// DONE  | result valid, held until RESULT_READY
module negate_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] DATA0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DATA1,
    output logic             GNT0,
    output logic             GNT1,
    output logic [WIDTH-1:0] RESULT,
    output logic             RESULT_ID,
    output logic             RESULT_VALID,
    input  logic             RESULT_READY,
    output logic             BUSY
`ifdef NEG_OVF_EN
    ,
    output logic             OVF
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             pri_q, pri_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             id_q, id_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_id_q, result_id_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             winner;

`ifdef NEG_OVF_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic ovf_q, ovf_d;
`endif

    // A lone requester always wins; on contention the priority bit decides.
    assign winner = (REQ0 && REQ1) ? pri_q : REQ1;

    always_comb begin
        state_d     = state_q;
        pri_d       = pri_q;
        op_d        = op_q;
        id_d        = id_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        result_d    = result_q;
        result_id_d = result_id_q;
        valid_d     = valid_q;
`ifdef NEG_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    op_d    = winner ? DATA1 : DATA0;
                    id_d    = winner;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                result_d    = ~op_q + WIDTH'(1);
                result_id_d = id_q;
                valid_d     = 1'b1;
`ifdef NEG_OVF_EN
                ovf_d       = (op_q == MOST_NEG);
`endif
                state_d     = DONE;
            end
            DONE: begin
                if (RESULT_READY) begin
                    valid_d = 1'b0;
                    pri_d   = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            pri_q       <= 1'b0;
            op_q        <= '0;
            id_q        <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            result_q    <= '0;
            result_id_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NEG_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pri_q       <= pri_d;
            op_q        <= op_d;
            id_q        <= id_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
`ifdef NEG_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign GNT0         = gnt0_q;
    assign GNT1         = gnt1_q;
    assign RESULT       = result_q;
    assign RESULT_ID    = result_id_q;
    assign RESULT_VALID = valid_q;
    assign BUSY         = busy_q;
`ifdef NEG_OVF_EN
    assign OVF          = ovf_q;
`endif

endmodule

// File: tb/tb_negate_arbiter.sv
// Bench for negate_arbiter: vector table, READY-stall, reset-in-CAPT and
// continuous-contention sequences, results checked through a scoreboard queue.
module tb_negate_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ0 = 1'b0, REQ1 = 1'b0;
    logic [7:0] DATA0 = '0, DATA1 = '0;
    logic       GNT0, GNT1, RESULT_ID, RESULT_VALID, BUSY;
    logic [7:0] RESULT;
    logic       RESULT_READY = 1'b1;
`ifdef NEG_OVF_EN
    logic       OVF;
`endif

    negate_arbiter #(.WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .DATA0(DATA0), .REQ1(REQ1), .DATA1(DATA1),
        .GNT0(GNT0), .GNT1(GNT1),
        .RESULT(RESULT), .RESULT_ID(RESULT_ID), .RESULT_VALID(RESULT_VALID),
        .RESULT_READY(RESULT_READY), .BUSY(BUSY)
`ifdef NEG_OVF_EN
        , .OVF(OVF)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       r0, r1;
        logic [7:0] d0, d1;
        logic       id;
        logic [7:0] res;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       id;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] res, input logic id, input logic [7:0] operand);
        exp_t e;
        e.res = res;
        e.id  = id;
        e.ovf = (operand == 8'h80);
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({name, "_result"}, RESULT, e.res);
            chk({name, "_id"}, RESULT_ID, e.id);
`ifdef NEG_OVF_EN
            chk({name, "_ovf"}, OVF, e.ovf);
`endif
        end
    endtask

    function automatic logic [7:0] neg8(input logic [7:0] x);
        return 8'((9'h100 - {1'b0, x}) & 9'h0FF);
    endfunction

    vec_t vt[10];

    initial begin
        int n;
        int last;
        int grants;
        logic exp_pri;
        logic [7:0] exp_res;

        vt[0] = '{r0:1, r1:1, d0:8'h01, d1:8'h05, id:0, res:8'hFF};
        vt[1] = '{r0:0, r1:1, d0:8'h00, d1:8'h05, id:1, res:8'hFB};
        vt[2] = '{r0:1, r1:0, d0:8'h2F, d1:8'h00, id:0, res:8'hD1};
        vt[3] = '{r0:0, r1:1, d0:8'h00, d1:8'h00, id:1, res:8'h00};
        vt[4] = '{r0:0, r1:1, d0:8'h00, d1:8'h80, id:1, res:8'h80};
        vt[5] = '{r0:1, r1:1, d0:8'h10, d1:8'h20, id:0, res:8'hF0};
        vt[6] = '{r0:1, r1:1, d0:8'h33, d1:8'h44, id:1, res:8'hBC};
        vt[7] = '{r0:1, r1:0, d0:8'h7F, d1:8'h00, id:0, res:8'h81};
        vt[8] = '{r0:1, r1:0, d0:8'h01, d1:8'h00, id:0, res:8'hFF};
        vt[9] = '{r0:0, r1:1, d0:8'h00, d1:8'hFF, id:1, res:8'h01};

        #2;
        chk("rst_gnt0", GNT0, 0);
        chk("rst_gnt1", GNT1, 0);
        chk("rst_valid", RESULT_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_id", RESULT_ID, 0);
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            REQ0 = vt[i].r0; REQ1 = vt[i].r1;
            DATA0 = vt[i].d0; DATA1 = vt[i].d1;
            RESULT_READY = 1'b1;
            n = 0;
            do begin
                @(posedge CLK); #1; n++;
            end while (!(GNT0 || GNT1) && n < 4);
            chk($sformatf("v%0d_gnt_lat", i), n, 1);
            chk($sformatf("v%0d_gnt0", i), GNT0, !vt[i].id);
            chk($sformatf("v%0d_gnt1", i), GNT1, vt[i].id);
            chk($sformatf("v%0d_busy", i), BUSY, 1);
            push_exp(vt[i].res, vt[i].id, vt[i].id ? vt[i].d1 : vt[i].d0);
            REQ0 = 1'b0; REQ1 = 1'b0;
            DATA0 = 8'hA5; DATA1 = 8'h5A;
            @(posedge CLK); #1;
            chk($sformatf("v%0d_gnt_pulse", i), {GNT0, GNT1}, 0);
            chk($sformatf("v%0d_valid", i), RESULT_VALID, 1);
            if (RESULT_VALID) pop_cmp($sformatf("v%0d", i));
            @(posedge CLK); #1;
            chk($sformatf("v%0d_valid_drop", i), RESULT_VALID, 0);
            chk($sformatf("v%0d_idle", i), BUSY, 0);
        end

        // Consumer stall in DONE with a competing request present.
        @(negedge CLK);
        REQ0 = 1'b1; DATA0 = 8'h5A; RESULT_READY = 1'b0;
        @(posedge CLK); #1;
        chk("stall_gnt0", GNT0, 1);
        push_exp(8'hA6, 1'b0, 8'h5A);
        REQ0 = 1'b0;
        @(posedge CLK); #1;
        chk("stall_valid", RESULT_VALID, 1);
        if (RESULT_VALID) pop_cmp("stall");
        REQ1 = 1'b1; DATA1 = 8'h77;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            chk("stall_hold_valid", RESULT_VALID, 1);
            chk("stall_hold_result", RESULT, 8'hA6);
            chk("stall_hold_id", RESULT_ID, 0);
            chk("stall_hold_busy", BUSY, 1);
            chk("stall_no_gnt", {GNT0, GNT1}, 0);
        end
        REQ1 = 1'b0; RESULT_READY = 1'b1;
        @(posedge CLK); #1;
        chk("stall_release_valid", RESULT_VALID, 0);
        chk("stall_release_busy", BUSY, 0);

        // Reset while in CAPT drops the operation.
        @(negedge CLK);
        REQ0 = 1'b1; DATA0 = 8'h11;
        @(posedge CLK); #1;
        chk("rcapt_gnt0", GNT0, 1);
        REQ0 = 1'b0;
        RESET = 1'b0;
        #1;
        chk("rcapt_gnt_low", {GNT0, GNT1}, 0);
        chk("rcapt_valid_low", RESULT_VALID, 0);
        chk("rcapt_busy_low", BUSY, 0);
        @(negedge CLK);
        RESET = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            chk("rcapt_no_stale", {RESULT_VALID, GNT0, GNT1, BUSY}, 0);
        end
        chk("rcapt_result_zero", RESULT, 0);

        // Continuous contention: alternate grants, one op per 3 cycles.
        @(negedge CLK);
        REQ0 = 1'b1; REQ1 = 1'b1; DATA0 = 8'h03; DATA1 = 8'h09; RESULT_READY = 1'b1;
        exp_pri = 1'b0;
        last = -1;
        grants = 0;
        for (int c = 0; c < 13; c++) begin
            @(posedge CLK); #1;
            if (GNT0 || GNT1) begin
                chk("rr_gnt_id", {GNT0, GNT1}, exp_pri ? 2'b01 : 2'b10);
                if (last >= 0) chk("rr_gap", c - last, 3);
                last = c;
                grants++;
                exp_res = neg8(exp_pri ? 8'h09 : 8'h03);
                push_exp(exp_res, exp_pri, exp_pri ? 8'h09 : 8'h03);
                exp_pri = ~exp_pri;
            end
            if (RESULT_VALID) pop_cmp("rr");
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        chk("rr_grants", grants, 5);
        n = 0;
        while ((BUSY || sb.size() != 0) && n < 6) begin
            @(posedge CLK); #1; n++;
            if (RESULT_VALID) pop_cmp("rr_drain");
        end
        chk("rr_drain_done", sb.size(), 0);
        chk("rr_final_idle", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
